// File: rtl/vend_ctrl_multi_pkg.sv
// Shared types and coin helpers for the multi-item vending controller.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_VEND,
        ST_CHANGE,
        ST_DONE
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_25   = 2'b11;

    // Face value in units of a coin code; COIN_NONE is worth nothing.
    function automatic logic [7:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  coin_value = 8'd5;
            COIN_10: coin_value = 8'd10;
            COIN_25: coin_value = 8'd25;
            default: coin_value = 8'd0;
        endcase
    endfunction

    // Largest coin not exceeding the balance; COIN_NONE when nothing fits.
    function automatic logic [1:0] change_coin(input int unsigned bal);
        if (bal >= 32'd25)
            change_coin = COIN_25;
        else if (bal >= 32'd10)
            change_coin = COIN_10;
        else if (bal >= 32'd5)
            change_coin = COIN_5;
        else
            change_coin = COIN_NONE;
    endfunction

endpackage

// File: rtl/vend_ctrl_multi_if.sv
// Front-panel / actuator bundle of the vending controller.
// master = panel side (drives requests), slave = controller.
interface vend_ctrl_multi_if #(
    parameter int N_ITEMS = 4,
    parameter int BAL_W   = 8
);
    localparam int SEL_W = $clog2(N_ITEMS);

    logic             start;
    logic [SEL_W-1:0] item_sel;
    logic             coin_valid;
    logic [1:0]       coin_sel;
    logic             cancel;
    logic             restock;

    logic             busy;
    logic             sold_out;
    logic             coin_reject;
    logic             vend_valid;
    logic [SEL_W-1:0] vend_item;
    logic             chg_valid;
    logic [1:0]       chg_coin;
    logic [BAL_W-1:0] bal_out;
    logic             done;

    modport master (
        output start, item_sel, coin_valid, coin_sel, cancel, restock,
        input  busy, sold_out, coin_reject, vend_valid, vend_item,
               chg_valid, chg_coin, bal_out, done
    );

    modport slave (
        input  start, item_sel, coin_valid, coin_sel, cancel, restock,
        output busy, sold_out, coin_reject, vend_valid, vend_item,
               chg_valid, chg_coin, bal_out, done
    );
endinterface

// File: rtl/vend_stock.sv
// Per-item stock counters: decrement on dispense, bulk reload, empty flags.
module vend_stock #(
    parameter int N_ITEMS    = 4,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dec_en,
    input  logic [$clog2(N_ITEMS)-1:0] dec_idx,
    input  logic                       reload,
    output logic [N_ITEMS-1:0]         empty
);
    localparam int SEL_W = $clog2(N_ITEMS);

    logic [STOCK_W-1:0] cnt [N_ITEMS];

    // Counters reload on reset or restock; a dispense takes one unit, never below zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_ITEMS; i++)
                cnt[i] <= STOCK_W'(INIT_STOCK);
        end else if (reload) begin
            for (int i = 0; i < N_ITEMS; i++)
                cnt[i] <= STOCK_W'(INIT_STOCK);
        end else if (dec_en) begin
            for (int i = 0; i < N_ITEMS; i++)
                if (dec_idx == SEL_W'(i) && cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
        end
    end

    // Empty flag per item.
    always_comb begin
        for (int i = 0; i < N_ITEMS; i++)
            empty[i] = (cnt[i] == '0);
    end
endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: purchase FSM, balance register,
// coin acceptance with overflow rejection and greedy change return.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int                          N_ITEMS     = 4,
    parameter int                          BAL_W       = 8,
    parameter int                          STOCK_W     = 4,
    parameter int                          INIT_STOCK  = 3,
    parameter logic [N_ITEMS*BAL_W-1:0]    PRICE_TABLE = {8'd35, 8'd20, 8'd15, 8'd10}
) (
    input  logic               clk,
    input  logic               reset,
    vend_ctrl_multi_if.slave   bus
);
    localparam int SEL_W = $clog2(N_ITEMS);

    // Reject bad configurations at elaboration time.
    generate
        if (N_ITEMS < 2) begin : g_bad_items
            $error("vend_ctrl_multi: N_ITEMS must be at least 2");
        end
        if (BAL_W < 5) begin : g_bad_bal
            $error("vend_ctrl_multi: BAL_W must hold a 25-unit coin");
        end
        for (genvar g = 0; g < N_ITEMS; g++) begin : g_price_chk
            localparam int P = int'(PRICE_TABLE[g*BAL_W +: BAL_W]);
            if (P == 0 || (P % 5) != 0) begin : g_bad_price
                $error("vend_ctrl_multi: price of item %0d (%0d) must be a nonzero multiple of 5", g, P);
            end
        end
    endgenerate

    state_t           state_q;
    logic [BAL_W-1:0] bal_q;
    logic [BAL_W-1:0] price_q;
    logic [SEL_W-1:0] item_q;

    logic             busy_q;
    logic             sold_out_q;
    logic             coin_reject_q;
    logic             vend_valid_q;
    logic [SEL_W-1:0] vend_item_q;
    logic             chg_valid_q;
    logic [1:0]       chg_coin_q;
    logic             done_q;

    logic [N_ITEMS-1:0] empty;
    logic [BAL_W-1:0]   sel_price;
    logic               sel_empty;
    logic [BAL_W:0]     coin_sum;
    logic               coin_take;
    logic [BAL_W-1:0]   chg_val;
    logic [BAL_W-1:0]   bal_nxt;
    logic [1:0]         nxt_coin;

    // True when adding the coin keeps the balance within BAL_W bits.
    function automatic logic coin_fits(input logic [BAL_W:0] sum);
        return !sum[BAL_W];
    endfunction

    vend_stock #(
        .N_ITEMS    (N_ITEMS),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk     (clk),
        .reset   (reset),
        .dec_en  (state_q == ST_VEND),
        .dec_idx (item_q),
        .reload  (state_q == ST_IDLE && bus.restock && !bus.start),
        .empty   (empty)
    );

    // Price and stock status of the item currently selected on the panel;
    // an index beyond the item count reads as sold out.
    always_comb begin
        sel_price = '0;
        sel_empty = 1'b1;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (bus.item_sel == SEL_W'(i)) begin
                sel_price = PRICE_TABLE[i*BAL_W +: BAL_W];
                sel_empty = empty[i];
            end
        end
    end

    // Next balance: add an accepted coin, take the price, or pay out one change coin.
    always_comb begin
        coin_sum  = {1'b0, bal_q} + (BAL_W+1)'(coin_value(bus.coin_sel));
        coin_take = bus.coin_valid && (state_q == ST_COLLECT) &&
                    (bus.coin_sel != COIN_NONE) && coin_fits(coin_sum);
        chg_val   = BAL_W'(coin_value(change_coin(32'(bal_q))));
        bal_nxt   = bal_q;
        case (state_q)
            ST_COLLECT: if (coin_take) bal_nxt = coin_sum[BAL_W-1:0];
            ST_VEND:    bal_nxt = bal_q - price_q;
            ST_CHANGE:  bal_nxt = (chg_val == '0) ? '0 : bal_q - chg_val;
            default:    bal_nxt = bal_q;
        endcase
        nxt_coin = change_coin(32'(bal_nxt));
    end

    // Purchase FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            bal_q         <= '0;
            price_q       <= '0;
            item_q        <= '0;
            busy_q        <= 1'b0;
            sold_out_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            vend_valid_q  <= 1'b0;
            vend_item_q   <= '0;
            chg_valid_q   <= 1'b0;
            chg_coin_q    <= COIN_NONE;
            done_q        <= 1'b0;
        end else begin
            sold_out_q    <= 1'b0;
            coin_reject_q <= bus.coin_valid && !coin_take;
            vend_valid_q  <= 1'b0;
            chg_valid_q   <= 1'b0;
            chg_coin_q    <= COIN_NONE;
            done_q        <= 1'b0;
            bal_q         <= bal_nxt;

            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (sel_empty) begin
                            sold_out_q <= 1'b1;
                        end else begin
                            item_q  <= bus.item_sel;
                            price_q <= sel_price;
                            busy_q  <= 1'b1;
                            state_q <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    // Cancel wins over a completed payment; any coin this cycle is refunded too.
                    if (bus.cancel) begin
                        state_q     <= ST_CHANGE;
                        chg_valid_q <= (nxt_coin != COIN_NONE);
                        chg_coin_q  <= nxt_coin;
                    end else if (bal_q >= price_q) begin
                        state_q      <= ST_VEND;
                        vend_valid_q <= 1'b1;
                        vend_item_q  <= item_q;
                    end
                end
                ST_VEND: begin
                    state_q     <= ST_CHANGE;
                    chg_valid_q <= (nxt_coin != COIN_NONE);
                    chg_coin_q  <= nxt_coin;
                end
                ST_CHANGE: begin
                    // Leave as soon as the balance is paid out, so DONE follows the last coin.
                    if (bal_nxt == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        chg_valid_q <= (nxt_coin != COIN_NONE);
                        chg_coin_q  <= nxt_coin;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.sold_out    = sold_out_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.vend_valid  = vend_valid_q;
    assign bus.vend_item   = vend_item_q;
    assign bus.chg_valid   = chg_valid_q;
    assign bus.chg_coin    = chg_coin_q;
    assign bus.bal_out     = bal_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi: default build, a single-stock build
// and a 5-bit balance build, each driven through its own interface.
module tb_vend_ctrl_multi;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int         sel = 0;
    logic       start = 1'b0, cancel = 1'b0, restock = 1'b0, coin_valid = 1'b0;
    logic [1:0] item_sel = 2'd0, coin_sel = 2'd0;

    int checks = 0;
    int errors = 0;

    vend_ctrl_multi_if #(.N_ITEMS(4), .BAL_W(8)) ifa ();
    vend_ctrl_multi_if #(.N_ITEMS(4), .BAL_W(8)) ifb ();
    vend_ctrl_multi_if #(.N_ITEMS(4), .BAL_W(5)) ifc ();

    assign ifa.start = (sel == 0) && start;  assign ifb.start = (sel == 1) && start;  assign ifc.start = (sel == 2) && start;
    assign ifa.cancel = (sel == 0) && cancel; assign ifb.cancel = (sel == 1) && cancel; assign ifc.cancel = (sel == 2) && cancel;
    assign ifa.restock = (sel == 0) && restock; assign ifb.restock = (sel == 1) && restock; assign ifc.restock = (sel == 2) && restock;
    assign ifa.coin_valid = (sel == 0) && coin_valid; assign ifb.coin_valid = (sel == 1) && coin_valid; assign ifc.coin_valid = (sel == 2) && coin_valid;
    assign ifa.item_sel = item_sel; assign ifb.item_sel = item_sel; assign ifc.item_sel = item_sel;
    assign ifa.coin_sel = coin_sel; assign ifb.coin_sel = coin_sel; assign ifc.coin_sel = coin_sel;

    vend_ctrl_multi #(.N_ITEMS(4), .BAL_W(8), .STOCK_W(4), .INIT_STOCK(3),
                      .PRICE_TABLE({8'd35, 8'd20, 8'd15, 8'd10}))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));
    vend_ctrl_multi #(.N_ITEMS(4), .BAL_W(8), .STOCK_W(4), .INIT_STOCK(1),
                      .PRICE_TABLE({8'd35, 8'd20, 8'd15, 8'd10}))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));
    vend_ctrl_multi #(.N_ITEMS(4), .BAL_W(5), .STOCK_W(4), .INIT_STOCK(3),
                      .PRICE_TABLE({5'd30, 5'd20, 5'd15, 5'd10}))
        dut_c (.clk(clk), .reset(reset), .bus(ifc));

    logic       o_busy, o_sold, o_rej, o_vend, o_chg, o_done;
    logic [1:0] o_item, o_coin;
    logic [7:0] o_bal;

    // Outputs of whichever instance is under test.
    always_comb begin
        case (sel)
            0: begin
                o_busy = ifa.busy; o_sold = ifa.sold_out; o_rej = ifa.coin_reject;
                o_vend = ifa.vend_valid; o_item = ifa.vend_item; o_chg = ifa.chg_valid;
                o_coin = ifa.chg_coin; o_bal = ifa.bal_out; o_done = ifa.done;
            end
            1: begin
                o_busy = ifb.busy; o_sold = ifb.sold_out; o_rej = ifb.coin_reject;
                o_vend = ifb.vend_valid; o_item = ifb.vend_item; o_chg = ifb.chg_valid;
                o_coin = ifb.chg_coin; o_bal = ifb.bal_out; o_done = ifb.done;
            end
            default: begin
                o_busy = ifc.busy; o_sold = ifc.sold_out; o_rej = ifc.coin_reject;
                o_vend = ifc.vend_valid; o_item = ifc.vend_item; o_chg = ifc.chg_valid;
                o_coin = ifc.chg_coin; o_bal = {3'b000, ifc.bal_out}; o_done = ifc.done;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] c);
        coin_valid = 1'b1;
        coin_sel   = c;
        tick();
        coin_valid = 1'b0;
        coin_sel   = 2'b00;
    endtask

    task automatic buy(input logic [1:0] item);
        start    = 1'b1;
        item_sel = item;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_bal", 32'(o_bal), 0);
        chk("rst_vend", 32'(o_vend), 0);
        chk("rst_chg", 32'(o_chg), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_stock3", 32'(dut_a.u_stock.cnt[3]), 3);
        @(negedge clk);
        reset = 1'b1;

        // Item 3 (35): 10+10+25 = 45, one 10 coin change
        buy(2'd3);
        chk("t1_busy", 32'(o_busy), 1);
        chk("t1_sold", 32'(o_sold), 0);
        coin(2'b10); chk("t1_bal10", 32'(o_bal), 10);
        coin(2'b10); chk("t1_bal20", 32'(o_bal), 20);
        coin(2'b11); chk("t1_bal45", 32'(o_bal), 45);
        chk("t1_novend_yet", 32'(o_vend), 0);
        tick();
        chk("t1_vend", 32'(o_vend), 1);
        chk("t1_vitem", 32'(o_item), 3);
        chk("t1_vbal", 32'(o_bal), 45);
        tick();
        chk("t1_vend_pulse", 32'(o_vend), 0);
        chk("t1_chg", 32'(o_chg), 1);
        chk("t1_coin", 32'(o_coin), 2);
        chk("t1_cbal", 32'(o_bal), 10);
        tick();
        chk("t1_chg_end", 32'(o_chg), 0);
        chk("t1_done", 32'(o_done), 1);
        chk("t1_bal0", 32'(o_bal), 0);
        chk("t1_stock3", 32'(dut_a.u_stock.cnt[3]), 2);
        tick();
        chk("t1_done_pulse", 32'(o_done), 0);
        chk("t1_idle", 32'(o_busy), 0);

        // Coin while idle is rejected
        coin(2'b10);
        chk("idle_rej", 32'(o_rej), 1);
        chk("idle_bal", 32'(o_bal), 0);

        // Item 1 (15): exact payment 5+10, null coin rejected on the way
        buy(2'd1);
        chk("idle_rej_pulse", 32'(o_rej), 0);
        coin(2'b01); chk("t2_bal5", 32'(o_bal), 5);
        coin(2'b00);
        chk("t2_null_rej", 32'(o_rej), 1);
        chk("t2_null_bal", 32'(o_bal), 5);
        coin(2'b10); chk("t2_bal15", 32'(o_bal), 15);
        tick();
        chk("t2_vend", 32'(o_vend), 1);
        chk("t2_vitem", 32'(o_item), 1);
        tick();
        chk("t2_nochg", 32'(o_chg), 0);
        chk("t2_nodone", 32'(o_done), 0);
        chk("t2_bal0", 32'(o_bal), 0);
        tick();
        chk("t2_done", 32'(o_done), 1);
        tick();
        chk("t2_idle", 32'(o_busy), 0);

        // Item 2: 25 then cancel -> 25 refunded, no vend, stock kept
        buy(2'd2);
        coin(2'b11); chk("t3_bal25", 32'(o_bal), 25);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("t3_novend", 32'(o_vend), 0);
        chk("t3_chg", 32'(o_chg), 1);
        chk("t3_coin", 32'(o_coin), 3);
        tick();
        chk("t3_chg_end", 32'(o_chg), 0);
        chk("t3_done", 32'(o_done), 1);
        chk("t3_novend2", 32'(o_vend), 0);
        chk("t3_stock2", 32'(dut_a.u_stock.cnt[2]), 3);
        tick();

        // Item 3: 25+25, cancel with a 10 coin (refunded 60); coin in CHANGE rejected; reset mid-change
        buy(2'd3);
        coin(2'b11);
        coin(2'b11); chk("t6_bal50", 32'(o_bal), 50);
        cancel = 1'b1; coin_valid = 1'b1; coin_sel = 2'b10;
        tick();
        cancel = 1'b0; coin_valid = 1'b0; coin_sel = 2'b00;
        chk("t6_bal60", 32'(o_bal), 60);
        chk("t6_chg25", 32'(o_coin), 3);
        chk("t6_norej", 32'(o_rej), 0);
        coin(2'b01);
        chk("t6_rej", 32'(o_rej), 1);
        chk("t6_bal35", 32'(o_bal), 35);
        chk("t6_chg", 32'(o_chg), 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(o_busy), 0);
        chk("t6_rst_bal", 32'(o_bal), 0);
        chk("t6_rst_chg", 32'(o_chg), 0);
        chk("t6_rst_rej", 32'(o_rej), 0);
        chk("t6_rst_stock3", 32'(dut_a.u_stock.cnt[3]), 3);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("t6_post_busy", 32'(o_busy), 0);
        chk("t6_post_vend", 32'(o_vend), 0);
        chk("t6_post_done", 32'(o_done), 0);

        // INIT_STOCK=1: second purchase of item 0 is sold out until restock
        sel = 1;
        buy(2'd0);
        coin(2'b10);
        tick();
        chk("t4_vend", 32'(o_vend), 1);
        tick(); tick();
        chk("t4_done", 32'(o_done), 1);
        tick();
        buy(2'd0);
        chk("t4_sold", 32'(o_sold), 1);
        chk("t4_busy0", 32'(o_busy), 0);
        tick();
        chk("t4_sold_pulse", 32'(o_sold), 0);
        restock = 1'b1;
        tick();
        restock = 1'b0;
        buy(2'd0);
        chk("t4_restock_busy", 32'(o_busy), 1);
        chk("t4_restock_sold", 32'(o_sold), 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("t4_cancel_nochg", 32'(o_chg), 0);
        tick();
        chk("t4_cancel_done", 32'(o_done), 1);
        tick();

        // BAL_W=5: 25 then 10 overflows (rejected), 5 completes the 30 price exactly
        sel = 2;
        buy(2'd3);
        coin(2'b11); chk("t5_bal25", 32'(o_bal), 25);
        coin(2'b10);
        chk("t5_rej", 32'(o_rej), 1);
        chk("t5_bal_kept", 32'(o_bal), 25);
        coin(2'b01);
        chk("t5_bal30", 32'(o_bal), 30);
        chk("t5_norej", 32'(o_rej), 0);
        tick();
        chk("t5_vend", 32'(o_vend), 1);
        chk("t5_vitem", 32'(o_item), 3);
        tick();
        chk("t5_nochg", 32'(o_chg), 0);
        chk("t5_bal0", 32'(o_bal), 0);
        tick();
        chk("t5_done", 32'(o_done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vend_ctrl_multi.md
# vend_ctrl_multi

Parametrised, single-block successor to the split datapath/controller vending machine. Supports N selectable items with a per-item price table, per-item stock counters, coin acceptance with overflow rejection, purchase cancel with full refund, and greedy change return one coin per cycle. Sits between the coin/item front panel and the dispense/change actuators. It replaces the fixed four-item controller plus datapath pair.

## Interface
- N_ITEMS, 4, number of selectable items (≥2)
- BAL_W, 8, balance/price width in units
- STOCK_W, 4, per-item stock counter width
- INIT_STOCK, 3, stock loaded into every item on reset/restock
- PRICE_TABLE, {8'd35,8'd20,8'd15,8'd10}, packed N_ITEMS×BAL_W prices, item 0 in LSBs; every price must be a nonzero multiple of 5 (elaboration check)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin purchase of item_sel (sampled in IDLE only)
- item_sel  in  $clog2(N_ITEMS)  item index
- coin_valid  in  1  one coin presented this cycle
- coin_sel  in  2  coin code: 01=5, 10=10, 11=25, 00=ignored
- cancel  in  1  abort purchase, refund balance
- restock  in  1  reload all stock counters (IDLE only)
- busy  out  1  high in any state but IDLE
- sold_out  out  1  one-cycle pulse: start on empty item
- coin_reject  out  1  one-cycle pulse: coin not accepted
- vend_valid  out  1  one-cycle dispense strobe
- vend_item  out  $clog2(N_ITEMS)  item dispensed (valid with vend_valid)
- chg_valid  out  1  one coin of change this cycle
- chg_coin  out  2  change coin code (same encoding as coin_sel)
- bal_out  out  BAL_W  current balance
- done  out  1  one-cycle pulse: transaction complete

## Operation
- States: IDLE, COLLECT, VEND, CHANGE, DONE.
- Reset (async, active-low): state IDLE; balance 0; latched price/item 0; every stock counter = INIT_STOCK; all outputs 0.
- IDLE, start=1:
  - stock[item_sel]==0: pulse sold_out and stay IDLE.
  - Otherwise latch item and price, then go to COLLECT.
- IDLE, restock=1 (start=0): all stock counters = INIT_STOCK. restock is ignored outside IDLE.
- COLLECT, valid coin:
  - If balance + value ≤ 2^BAL_W−1, add it.
  - Otherwise pulse coin_reject and leave the balance unchanged.
  - coin_sel=00 with coin_valid is rejected.
- COLLECT exit:
  - cancel=1 → CHANGE (refund). A coin in the same cycle is still accepted and refunded.
  - Else registered balance ≥ price → VEND.
- VEND (1 cycle): vend_valid=1, vend_item=latched item; balance −= price; stock[item] −= 1; → CHANGE.
- CHANGE: while balance ≠ 0, output the largest coin ≤ balance (25, then 10, then 5) each cycle, and subtract it. When balance == 0 → DONE, including when entered with balance 0.
- DONE (1 cycle): done=1; → IDLE.
- Coins outside COLLECT → coin_reject pulse, balance unchanged. start outside IDLE is ignored. cancel outside COLLECT is ignored.
- Arithmetic: unsigned BAL_W; the subtract never underflows because VEND requires balance ≥ price.

## Timing
- All outputs are registered or Moore-decoded from state. No combinational input-to-output paths.
- start at edge N → COLLECT at N (busy=1 from N); sold_out is high for the cycle after N.
- Coin accepted at edge N → bal_out updated after N. If bal ≥ price, state = VEND after edge N+1, vend_valid for one cycle.
- Change coins: one per cycle starting the cycle after VEND; k coins take k cycles; DONE follows the last coin.
- Exact payment: VEND, CHANGE (0 cycles of chg_valid, 1 cycle in state), DONE.
- Reset mid-transaction: immediate return to IDLE. Balance is lost (no refund), stock is restored to INIT_STOCK, and there is no vend/done pulse.

## Structure
- Package vend_pkg: state enum; coin code constants (COIN_NONE/5/10/25); coin value function; greedy-change function.
- One sub-module, vend_stock: N_ITEMS counters with decrement/reload/empty-flag. The FSM, balance register and change logic live in the top.

## Test plan
- Item 3 (35), coins 10,10,25 → bal 45; vend_valid with vend_item=3; one chg_coin=10; done; stock[3]=2.
- Item 1 (15), coins 5,10 → vend_valid; no chg_valid; done two cycles after vend_valid; bal 0.
- Item 2, coin 25 then cancel → chg_coin=25 once; no vend_valid; stock[2] unchanged; done.
- INIT_STOCK=1: buy item 0 twice → second start gives sold_out pulse, busy stays 0; restock then start succeeds.
- BAL_W=5 (max 31), item 3 price 30: coins 25 then 10 → second coin rejected (coin_reject), bal 25; coin 5 → vend, no change.
- Reset low during CHANGE with bal 35 → all outputs 0 next cycle, state IDLE, stock = INIT_STOCK; coin during CHANGE → coin_reject.
